// File: rtl/mic1_io_pkg.sv
// Shared constants and types for the Mic-1 memory-mapped UART block.
package mic1_io_pkg;

  localparam logic [31:0] DATA_ADDR_DEF   = 32'hFFFF_FFFD;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'hFFFF_FFFC;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_TX_IDLE  = 3;
  localparam int ST_COUNT    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/mic1_uart_io.sv
// Memory-mapped UART responder for the Mic-1 bus with queued RX/TX.
module mic1_uart_io
  import mic1_io_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 4,
  parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        hit,
  output logic        stall,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [7:0]  rx_data
);

  logic                data_hit, stat_hit;
  logic                rd_data, wr_data, rd_stat;
  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]          rx_head, tx_head;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic                rx_overrun, overrun_evt;
  logic [31:0]         status;
  tx_state_t           state;
  logic                unused_bits;

  assign unused_bits = ^{mem_wdata[31:8], tx_count};

  assign data_hit = mem_addr == DATA_ADDR;
  assign stat_hit = mem_addr == STATUS_ADDR;
  assign hit      = data_hit || stat_hit;

  assign rd_data = run && mem_read  && data_hit;
  assign wr_data = run && mem_write && data_hit;
  assign rd_stat = run && mem_read  && stat_hit;

  assign stall   = wr_data && tx_full;
  assign tx_push = wr_data && !tx_full;
  assign rx_pop  = rd_data && !rx_empty;

  assign overrun_evt = rx_done && rx_full && !rx_pop;
  assign rx_push     = rx_done && !overrun_evt;
  assign tx_pop      = (state == IDLE) && !tx_empty && !tx_busy;

  always_comb begin
    status = '0;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_OVERRUN]  = rx_overrun;
    status[ST_TX_IDLE]  = tx_empty && (state == IDLE);
    status[ST_COUNT +: DEPTH_LOG2+1] = rx_count;
  end

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .resetn(resetn),
    .push(rx_push), .pop(rx_pop), .din(rx_data), .dout(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .resetn(resetn),
    .push(tx_push), .pop(tx_pop), .din(mem_wdata[7:0]), .dout(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rdata  <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rd_data)      mem_rdata <= rx_empty ? 32'd0 : {24'd0, rx_head};
      else if (rd_stat) mem_rdata <= status;
      // A fresh overrun beats the clear-on-read in the same cycle.
      if (overrun_evt)  rx_overrun <= 1'b1;
      else if (rd_stat) rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      unique case (state)
        IDLE: if (tx_pop) begin
          tx_data <= tx_head;
          state   <= LOAD;
        end
        LOAD: begin
          tx_start <= 1'b1;
          state    <= START;
        end
        START: if (tx_busy) begin
          tx_start <= 1'b0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic1_uart_io.sv
// Scoreboard bench for mic1_uart_io: bus reads and TX bytes checked by monitors.
module tb_mic1_uart_io;

  localparam logic [31:0] DA = 32'hFFFF_FFFD;
  localparam logic [31:0] SA = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        resetn, run, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        hit, stall, tx_start, tx_busy, rx_done;
  logic [7:0]  tx_data, rx_data;
  logic        force_busy = 1'b0;
  logic        model_en = 1'b0;
  logic        model_busy = 1'b0;
  int          model_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rdq[$];
  logic [7:0]  txq[$];
  logic        prev_start = 1'b0;

  always #5 clk = ~clk;
  assign tx_busy = force_busy | model_busy;

  mic1_uart_io dut (
    .clk(clk), .resetn(resetn), .run(run),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit(hit), .stall(stall),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_done(rx_done), .rx_data(rx_data)
  );

  // Simple uart_tx stand-in: goes busy after seeing tx_start.
  always @(posedge clk) begin
    if (model_busy) begin
      if (model_cnt == 0) model_busy <= 1'b0;
      else model_cnt <= model_cnt - 1;
    end else if (model_en && tx_start) begin
      model_busy <= 1'b1;
      model_cnt  <= 3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read monitor: any qualified hit read must match the next expectation.
  always @(posedge clk) begin
    if (resetn && run && mem_read && (mem_addr == DA || mem_addr == SA)) begin
      #1;
      if (rdq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_orphan: got %h expected none", mem_rdata);
      end else begin
        chk("mem_rdata", mem_rdata, rdq.pop_front());
      end
    end
  end

  // TX monitor: every rising tx_start must carry the next queued byte.
  always @(posedge clk) begin
    #1;
    if (tx_start && !prev_start) begin
      if (txq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_orphan: got %h expected none", tx_data);
      end else begin
        chk("tx_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
      end
    end
    prev_start = tx_start;
  end

  task automatic rx_byte(input logic [7:0] b);
    rx_done = 1'b1; rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    mem_read = 1'b1; mem_addr = a;
    rdq.push_back(exp);
    @(negedge clk);
    mem_read = 1'b0; mem_addr = 32'h0;
  endtask

  task automatic wr(input logic [7:0] d, input bit exp_tx);
    mem_write = 1'b1; mem_addr = DA; mem_wdata = {24'hABCDEF, d};
    if (exp_tx) txq.push_back(d);
    @(negedge clk);
    mem_write = 1'b0; mem_addr = 32'h0;
  endtask

  initial begin
    resetn = 1'b0; run = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; rx_done = 1'b0; rx_data = 8'h0;
    #1;
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_start", {31'd0, tx_start}, 32'h0);
    chk("rst_txdata", {24'd0, tx_data}, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1; run = 1'b1;
    rd(SA, 32'h0000_0008);

    // Basic RX path, plus a read with run low that must not pop.
    rx_byte(8'h41); rx_byte(8'h42); rx_byte(8'h43);
    run = 1'b0; mem_read = 1'b1; mem_addr = DA;
    @(negedge clk);
    mem_read = 1'b0; run = 1'b1;
    rd(DA, 32'h41); rd(DA, 32'h42); rd(DA, 32'h43);
    rd(DA, 32'h0);
    rd(SA, 32'h0000_0008);

    // Overrun: 17 bytes, 17th dropped.
    for (int i = 1; i <= 17; i++) rx_byte(8'(i));
    rd(SA, 32'h0000_100D);
    rd(SA, 32'h0000_1009);
    for (int i = 1; i <= 16; i++) rd(DA, 32'(i));
    rd(DA, 32'h0);

    // Full RX with simultaneous pop and push.
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h60 + i));
    rx_done = 1'b1; rx_data = 8'h99;
    mem_read = 1'b1; mem_addr = DA; rdq.push_back(32'h60);
    @(negedge clk);
    rx_done = 1'b0; mem_read = 1'b0;
    rd(SA, 32'h0000_1009);
    for (int i = 1; i < 16; i++) rd(DA, 32'(8'h60 + i));
    rd(DA, 32'h99);
    rd(DA, 32'h0);

    // TX fill with busy held, then a stalled 17th write.
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_write = 1'b1; mem_addr = DA;
      #1 chk("no_stall", {31'd0, stall}, 32'h0);
      wr(8'(8'hA0 + i), 1'b1);
    end
    rd(SA, 32'h0000_0002);
    mem_write = 1'b1; mem_addr = DA; mem_wdata = 32'hABCDEFB0;
    txq.push_back(8'hB0);
    #1 chk("hit", {31'd0, hit}, 32'h1);
    chk("stall_full", {31'd0, stall}, 32'h1);
    @(negedge clk);
    chk("stall_hold", {31'd0, stall}, 32'h1);
    force_busy = 1'b0; model_en = 1'b1;
    #1 chk("stall_pre_pop", {31'd0, stall}, 32'h1);
    @(negedge clk);
    chk("stall_clear", {31'd0, stall}, 32'h0);
    @(negedge clk);
    mem_write = 1'b0; mem_addr = 32'h0;
    for (int i = 0; i < 400 && txq.size() != 0; i++) @(negedge clk);
    if (txq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL tx_drain: got %0d left expected 0", txq.size());
    end
    repeat (10) @(negedge clk);
    rd(SA, 32'h0000_0008);

    // Single byte start timing.
    wr(8'h55, 1'b1);
    chk("start_e0", {31'd0, tx_start}, 32'h0);
    @(negedge clk);
    chk("start_e1", {31'd0, tx_start}, 32'h0);
    @(negedge clk);
    chk("start_e2", {31'd0, tx_start}, 32'h1);
    chk("txd_55", {24'd0, tx_data}, 32'h55);
    @(negedge clk);
    chk("start_held", {31'd0, tx_start}, 32'h1);
    @(negedge clk);
    chk("start_drop", {31'd0, tx_start}, 32'h0);
    for (int i = 0; i < 20 && tx_busy; i++) @(negedge clk);
    chk("busy_fell", {31'd0, tx_busy}, 32'h0);
    @(negedge clk);
    rd(SA, 32'h0000_0008);

    // Asynchronous reset while in START with both FIFOs loaded.
    model_en = 1'b0;
    rx_byte(8'h77); rx_byte(8'h78);
    rd(DA, 32'h77);
    wr(8'h11, 1'b1); wr(8'h22, 1'b0); wr(8'h33, 1'b0);
    chk("pre_rst_start", {31'd0, tx_start}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_start", {31'd0, tx_start}, 32'h0);
    chk("arst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd(SA, 32'h0000_0008);
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {31'd0, tx_start}, 32'h0);

    chk("rdq_empty", rdq.size(), 32'h0);
    chk("txq_empty", txq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mic1_uart_io.md
# mic1_uart_io

Memory-mapped UART responder for the Mic-1 data bus: decodes the core's `mem_read`/`mem_write` strobes at two fixed IO addresses and buffers traffic in both directions through small FIFOs. Sits between the `mic1` core and the `uart_rx`/`uart_tx` instances in `mic1_soc`. It replaces the single `received_register` and stall-on-`tx_busy` scheme with queued RX/TX, a status register and overrun detection.

## Interface
- `DEPTH_LOG2`, 4: log2 of each FIFO depth (16 entries).
- `DATA_ADDR`, 32'hFFFF_FFFD: read pops RX, write pushes TX.
- `STATUS_ADDR`, 32'hFFFF_FFFC: read-only status word.

- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: core-enable qualifier; bus strobes are ignored when low.
- `mem_read` in 1: core read strobe.
- `mem_write` in 1: core write strobe.
- `mem_addr` in 32: core word address.
- `mem_wdata` in 32: write data; only [7:0] used.
- `mem_rdata` out 32: registered read data.
- `hit` out 1: combinational; `mem_addr` equals `DATA_ADDR` or `STATUS_ADDR`. SoC uses it to steer its read mux.
- `stall` out 1: combinational; core must be held (`run` low next cycle) because a DATA write hit a full TX FIFO.
- `tx_start` out 1: to `uart_tx`.
- `tx_data` out 8: to `uart_tx`.
- `tx_busy` in 1: from `uart_tx`.
- `rx_done` in 1: one-cycle pulse from `uart_rx`.
- `rx_data` in 8: from `uart_rx`, valid with `rx_done`.

## Operation
- Access is valid only when strobe && `run` && address match. Other addresses are ignored, and `mem_rdata` holds its value.
- DATA read:
  - RX non-empty: pop; `mem_rdata` = {24'b0, head}.
  - RX empty: `mem_rdata` = 0, no pop.
- DATA write:
  - TX not full: push `mem_wdata[7:0]`.
  - TX full: no push and `stall` high; the write is retried by the core and accepted on the first cycle TX is not full.
- STATUS read, `mem_rdata` fields:
  - [0] rx_valid (RX non-empty)
  - [1] tx_full
  - [2] rx_overrun (sticky)
  - [3] tx_idle (TX empty and FSM in IDLE)
  - [8+:DEPTH_LOG2+1] RX count
  - all other bits 0
  - The read clears rx_overrun in the same edge. A new overrun in that same cycle wins, and the flag stays set.
- STATUS write: ignored.
- RX push: `rx_done` pushes `rx_data`.
  - RX full: byte dropped, rx_overrun set.
  - Pop and push in the same cycle on a full FIFO: both occur, count unchanged, no overrun.
- TX drain FSM:
  - IDLE → LOAD when TX non-empty and !`tx_busy`; pop into `tx_data` register.
  - LOAD → START.
  - START: `tx_start`=1, held until `tx_busy` is seen high → WAIT_DONE.
  - WAIT_DONE → IDLE when `tx_busy` low.
- FIFO pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2·depth. Full means pointers are equal except the MSB; empty means the pointers are equal.

## Timing
- Read latency 1: `mem_rdata` is updated on the edge that samples the access and is stable until the next hit read.
- DATA push/pop takes effect on the same edge; the next cycle's status reflects it.
- `rx_done` → rx_valid readable after 1 edge.
- TX FIFO non-empty with `tx_busy` low → `tx_start` rises 2 edges later (IDLE→LOAD→START).
- Reset values, asynchronous:
  - `mem_rdata`=0, `tx_start`=0, `tx_data`=0
  - both FIFOs empty, rx_overrun=0, FSM=IDLE
- `stall`/`hit` follow their inputs.
- Reset mid-frame: FIFO contents are discarded and `tx_start` drops immediately. A frame already inside `uart_tx` is not aborted by this block.

## Structure
- Package `mic1_io_pkg`:
  - default DATA/STATUS addresses
  - status bit index localparams
  - `tx_state_t` enum {IDLE, LOAD, START, WAIT_DONE}
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH_LOG2`; ports push/pop/din/dout/full/empty/count; async active-low reset; show-ahead dout), instantiated twice, 8-bit wide.

## Test plan
- Three `rx_done` pulses with 0x41, 0x42, 0x43, then three DATA reads → `mem_rdata` 0x41, 0x42, 0x43; a fourth read → 0; STATUS[0]=0.
- 17 `rx_done` pulses without reads → STATUS shows count 16 and bit2=1. A second STATUS read → bit2=0. The first DATA read returns byte 1; the 17th byte is lost.
- 16 DATA writes with `tx_busy` held high → no `stall`, STATUS[1]=1. A 17th write → `stall`=1 until `tx_busy` drops and the FSM pops; the write then completes.
- Write 0x55 with `uart_tx` model idle → `tx_start` high 2 cycles after the write edge, `tx_data`=0x55, held until `tx_busy` rises. STATUS[3]=1 after `tx_busy` falls.
- RX full, DATA read coincident with `rx_done`=0x99 → count stays 16, no overrun, 0x99 is last out.
- Assert `resetn` low mid-START with both FIFOs non-empty → `tx_start`, `mem_rdata` 0 asynchronously; after release STATUS = 0x0000_0008.
